vt100_command_encoder: RTL

//  Turns one abstract terminal command (char, IND/NEL/RI, CUU/CUD/CUF/CUB, CUP) into its VT100 byte stream.

---
 rtl/vt100_command_encoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vt100_command_encoder.sv
// vt100_command_encoder: serialises one abstract terminal command into its
// VT100 byte stream, one byte per valid/ready handshake on the tx port.
module vt100_command_encoder #(
  parameter bit         SHORT_CUP = 1'b1,
  parameter logic [7:0] CUP_FINAL = 8'h48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [3:0] cmdType,
  input  logic [7:0] Pn1,
  input  logic [7:0] Pn2,
  input  logic [7:0] Pchar,
  output logic [7:0] txData,
  output logic       txValid,
  input  logic       txReady,
  output logic       cmdDone,
  output logic       cmdError
);

  typedef enum logic [3:0] {
    IDLE, CHAR, ESC, BRKT, P1H, P1T, P1O, SEMI, P2H, P2T, P2O, FINAL
  } state_t;

  state_t     state, state_next;
  logic       accept;
  logic       err_p1;

  // Command fields captured at accept; digits are pre-split so the byte path
  // only selects registered nibbles.
  logic [7:0]  char_q;
  logic [7:0]  final_q;
  logic [11:0] dig1_q;
  logic [11:0] dig2_q;
  logic        is_cup_q;
  logic        is_short_q;
  logic        is_esc2_q;

  // Decimal split into {hundreds, tens, ones}, one nibble each.
  function automatic logic [11:0] dec_split(input logic [7:0] n);
    logic [7:0] h, t, o;
    h = n / 8'd100;
    t = (n % 8'd100) / 8'd10;
    o = n % 8'd10;
    return {h[3:0], t[3:0], o[3:0]};
  endfunction

  // Final byte of the escape sequence for a given command type.
  function automatic logic [7:0] final_byte(input logic [3:0] ty);
    case (ty)
      4'd1:    return 8'h44;
      4'd2:    return 8'h45;
      4'd3:    return 8'h4D;
      4'd4:    return 8'h41;
      4'd5:    return 8'h42;
      4'd6:    return 8'h43;
      4'd7:    return 8'h44;
      default: return CUP_FINAL;
    endcase
  endfunction

  // Leading zeros are suppressed: start at the most significant nonzero digit.
  function automatic state_t first_digit(input logic [11:0] d, input state_t sh,
                                         input state_t st, input state_t so);
    if (d[11:8] != 4'd0)     return sh;
    else if (d[7:4] != 4'd0) return st;
    else                     return so;
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  assign cmdReady = (state == IDLE) && rst;
  assign accept   = cmdValid && cmdReady;
  assign txValid  = (state != IDLE);
  assign cmdDone  = rst && txReady && ((state == CHAR) || (state == FINAL));
  assign cmdError = err_p1;

  // State register and the invalid-command error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      err_p1 <= 1'b0;
    end else begin
      state  <= state_next;
      err_p1 <= accept && (cmdType > 4'd8);
    end
  end

  // Latch command operands on accept; no reset needed, outputs key off state.
  always_ff @(posedge clk) begin
    if (accept) begin
      char_q     <= Pchar;
      final_q    <= final_byte(cmdType);
      dig1_q     <= dec_split(Pn1);
      dig2_q     <= dec_split(Pn2);
      is_cup_q   <= (cmdType == 4'd8);
      is_short_q <= SHORT_CUP && (cmdType == 4'd8) && (Pn1 == 8'd1) && (Pn2 == 8'd1);
      is_esc2_q  <= (cmdType >= 4'd1) && (cmdType <= 4'd3);
    end
  end

  // Next-state sequencing; byte states advance only on a handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmdType == 4'd0)      state_next = CHAR;
          else if (cmdType <= 4'd8) state_next = ESC;
        end
      end
      CHAR:  if (txReady) state_next = IDLE;
      ESC:   if (txReady) state_next = is_esc2_q ? FINAL : BRKT;
      BRKT:  if (txReady) state_next = is_short_q ? FINAL : first_digit(dig1_q, P1H, P1T, P1O);
      P1H:   if (txReady) state_next = P1T;
      P1T:   if (txReady) state_next = P1O;
      P1O:   if (txReady) state_next = is_cup_q ? SEMI : FINAL;
      SEMI:  if (txReady) state_next = first_digit(dig2_q, P2H, P2T, P2O);
      P2H:   if (txReady) state_next = P2T;
      P2T:   if (txReady) state_next = P2O;
      P2O:   if (txReady) state_next = FINAL;
      FINAL: if (txReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte presented for the current state; held while the sink stalls.
  always_comb begin
    txData = 8'h00;
    case (state)
      CHAR:  txData = char_q;
      ESC:   txData = 8'h1B;
      BRKT:  txData = 8'h5B;
      P1H:   txData = ascii_digit(dig1_q[11:8]);
      P1T:   txData = ascii_digit(dig1_q[7:4]);
      P1O:   txData = ascii_digit(dig1_q[3:0]);
      SEMI:  txData = 8'h3B;
      P2H:   txData = ascii_digit(dig2_q[11:8]);
      P2T:   txData = ascii_digit(dig2_q[7:4]);
      P2O:   txData = ascii_digit(dig2_q[3:0]);
      FINAL: txData = final_q;
      default: txData = 8'h00;
    endcase
  end

endmodule
